// File: rtl/pattern_pkg.sv
// Shared definitions for the serial test-pattern transmitter.
// Holds the one-hot state encoding (same style as the pattern detector),
// the reset pattern and the default widths.
package pattern_pkg;

    localparam int DEF_W  = 5;   // maximum pattern width
    localparam int DEF_RW = 8;   // repetition counter width
    localparam int DEF_GW = 4;   // gap counter width

    localparam logic [DEF_W-1:0] DEF_PATTERN = 5'b10110;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_SEND = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

endpackage

// File: rtl/pattern_shifter.sv
// W-bit parallel-load shift register with a bit-down-counter.
// Ports:
//   clk, rst      clock, async active-low reset
//   load_i        load pat_i / len_i (wins over shift_i)
//   shift_i       shift left one bit, decrement the bit counter
//   pat_i, len_i  pattern (MSB first) and number of bits to send
//   msb_o         current MSB, i.e. the bit being transmitted
//   last_o        high while the bit counter is on the final bit
module pattern_shifter
    import pattern_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [W-1:0]  pat_i,
    input  logic [LW-1:0] len_i,
    output logic          msb_o,
    output logic          last_o
);

    logic [W-1:0]  sr_q, sr_d;
    logic [LW-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = pat_i;
            cnt_d = len_i;
        end else if (shift_i && cnt_q != '0) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o  = sr_q[W-1];
    assign last_o = (cnt_q == LW'(1));

endmodule

// File: rtl/pattern_gen.sv
// Serial test-pattern transmitter: shifts a programmable pattern out
// MSB-first for a programmed number of repetitions, with an optional idle
// gap between repetitions. All outputs are registered, so they lag the FSM
// state by one cycle.
// Ports:
//   clk, rst     clock, async active-low reset
//   start        begin a burst (only honoured in IDLE)
//   pattern_in   pattern, MSB first
//   pat_len      valid bits from the MSB end; 0 or > W means W
//   reps         repetitions (0 -> straight to DONE)
//   gap          idle cycles between repetitions
//   data_out     serial bit, data_valid qualifies it
//   busy         burst in flight, done one-cycle end-of-burst pulse
module pattern_gen #(
    parameter int             W           = pattern_pkg::DEF_W,
    parameter logic [W-1:0]   DEF_PATTERN = W'(pattern_pkg::DEF_PATTERN),
    parameter int             RW          = pattern_pkg::DEF_RW,
    parameter int             GW          = pattern_pkg::DEF_GW,
    localparam int            LW          = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern_in,
    input  logic [LW-1:0] pat_len,
    input  logic [RW-1:0] reps,
    input  logic [GW-1:0] gap,
    output logic          data_out,
    output logic          data_valid,
    output logic          busy,
    output logic          done
);
    import pattern_pkg::*;

    state_e        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          dout_q, dout_d, dval_q, dval_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          sh_load, sh_shift, sh_msb, sh_last;
    logic [W-1:0]  sh_pat;
    logic [LW-1:0] sh_len;
    logic [LW-1:0] len_eff;

    assign len_eff = (pat_len == '0 || pat_len > LW'(W)) ? LW'(W) : pat_len;

    pattern_shifter #(.W(W), .LW(LW)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .pat_i   (sh_pat),
        .len_i   (sh_len),
        .msb_o   (sh_msb),
        .last_o  (sh_last)
    );

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        gap_d    = gap_q;
        rep_d    = rep_q;
        gcnt_d   = gcnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_pat   = pat_q;
        sh_len   = len_q;
        dout_d   = 1'b0;
        dval_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        // Shifter loads straight from the inputs so the
                        // first bit can go out on the very next edge.
                        pat_d   = pattern_in;
                        len_d   = len_eff;
                        gap_d   = gap;
                        rep_d   = reps;
                        sh_load = 1'b1;
                        sh_pat  = pattern_in;
                        sh_len  = len_eff;
                        busy_d  = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                busy_d   = 1'b1;
                dout_d   = sh_msb;
                dval_d   = 1'b1;
                sh_shift = 1'b1;
                if (sh_last) begin
                    rep_d = rep_q - RW'(1);
                    if (rep_q <= RW'(1)) begin
                        state_d = ST_DONE;
                    end else if (gap_q != '0) begin
                        gcnt_d  = gap_q;
                        state_d = ST_GAP;
                    end else begin
                        sh_load = 1'b1;   // back-to-back repetition
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gcnt_q <= GW'(1)) begin
                    gcnt_d  = '0;
                    sh_load = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= DEF_PATTERN;
            len_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
            dout_q  <= 1'b0;
            dval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            gcnt_q  <= gcnt_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dval_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: each accepted start pushes the complete
// expected per-cycle output trace; a monitor pops one entry per cycle.
module tb_pattern_gen;

    localparam int W  = 5;
    localparam int RW = 8;
    localparam int GW = 4;
    localparam int LW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  pattern_in = '0;
    logic [LW-1:0] pat_len = '0;
    logic [RW-1:0] reps = '0;
    logic [GW-1:0] gap = '0;
    logic          data_out, data_valid, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic busy;
        logic valid;
        logic data;
        logic done;
    } rec_t;

    localparam rec_t R_IDLE = 4'b0000;
    localparam rec_t R_BUSY = 4'b1000;
    localparam rec_t R_DONE = 4'b0001;

    rec_t exp_q[$];

    pattern_gen #(.W(W), .RW(RW), .GW(GW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_in (pattern_in),
        .pat_len    (pat_len),
        .reps       (reps),
        .gap        (gap),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: cycle-by-cycle trace starting the cycle after the start edge.
    function automatic void push_burst(logic [W-1:0] p, int len, int r, int g);
        int l;
        l = (len == 0 || len > W) ? W : len;
        if (r == 0) begin
            exp_q.push_back(R_IDLE);
            exp_q.push_back(R_DONE);
            return;
        end
        exp_q.push_back(R_BUSY);
        for (int i = 0; i < r; i++) begin
            for (int b = 0; b < l; b++)
                exp_q.push_back(rec_t'({1'b1, 1'b1, p[W-1-b], 1'b0}));
            if (i < r - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(R_BUSY);
        end
        exp_q.push_back(R_DONE);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
        end
    endtask

    // Monitor: one trace entry per cycle while a burst is expected,
    // otherwise the outputs must stay quiet.
    initial begin
        rec_t got, e;
        forever begin
            @(negedge clk);
            if (!rst) continue;
            got = rec_t'({busy, data_valid, data_out, done});
            checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL trace: busy/valid/data/done got %b required %b at %0t",
                             got, e, $time);
                end
            end else if (got !== R_IDLE) begin
                errors++;
                $display("FAIL idle: busy/valid/data/done got %b required 0000 at %0t",
                         got, $time);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the start edge.
    task automatic do_start(logic [W-1:0] p, logic [LW-1:0] l,
                            logic [RW-1:0] r, logic [GW-1:0] g);
        start = 1'b1; pattern_in = p; pat_len = l; reps = r; gap = g;
        @(posedge clk);
        push_burst(p, int'(l), int'(r), int'(g));
        #1;
        start      = 1'b0;
        pattern_in = W'($urandom);
        pat_len    = LW'($urandom);
        reps       = RW'($urandom);
        gap        = GW'($urandom);
    endtask

    // Wait for the trace to drain; optionally poke start/config mid-burst
    // (only while at least two more cycles of burst are outstanding).
    task automatic wait_idle(bit poke);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            start = poke && exp_q.size() >= 3 && ($urandom_range(0, 3) == 0);
            if (start) begin
                pattern_in = W'($urandom);
                reps       = RW'($urandom_range(1, 5));
                gap        = GW'($urandom);
            end
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d trace entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #7 rst = 1'b0;
        #1;
        chk("reset data_out",   32'(data_out),   32'd0);
        chk("reset data_valid", 32'(data_valid), 32'd0);
        chk("reset busy",       32'(busy),       32'd0);
        chk("reset done",       32'(done),       32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // single burst, back-to-back reps, short pattern with gap
        do_start(5'b10110, 3'd5, 8'd1, 4'd0); wait_idle(1'b0);
        do_start(5'b10110, 3'd5, 8'd3, 4'd0); wait_idle(1'b0);
        do_start(5'b11000, 3'd2, 8'd2, 4'd3); wait_idle(1'b0);
        // degenerate: reps = 0, pat_len = 0, pat_len above W
        do_start(5'b11111, 3'd5, 8'd0, 4'd2); wait_idle(1'b0);
        do_start(5'b10110, 3'd0, 8'd2, 4'd1); wait_idle(1'b0);
        do_start(5'b01101, 3'd7, 8'd1, 4'd0); wait_idle(1'b0);

        // start and new configuration mid-burst must be ignored
        do_start(5'b10011, 3'd5, 8'd2, 4'd2);
        @(posedge clk); #1;
        start = 1'b1; pattern_in = 5'b01001; pat_len = 3'd3; reps = 8'd7; gap = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(1'b0);

        // reset on the third bit: outputs drop at once, no done afterwards
        do_start(5'b10110, 3'd5, 8'd1, 4'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("third bit valid", 32'(data_valid), 32'd1);
        chk("third bit value", 32'(data_out),   32'd1);
        rst = 1'b0;
        #1;
        chk("async rst data_out",   32'(data_out),   32'd0);
        chk("async rst data_valid", 32'(data_valid), 32'd0);
        chk("async rst busy",       32'(busy),       32'd0);
        chk("async rst done",       32'(done),       32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_start(5'b10110, 3'd5, 8'd1, 4'd0); wait_idle(1'b0);

        // randomized bursts with random mid-burst pokes
        for (int t = 0; t < 40; t++) begin
            do_start(W'($urandom), LW'($urandom_range(0, 7)),
                     RW'($urandom_range(0, 4)), GW'($urandom_range(0, 3)));
            wait_idle(1'b1);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Serial test-pattern transmitter, the stimulus end of the serial pattern detector. The block shifts a programmable bit pattern out MSB-first, one bit per clock, for a programmed number of repetitions, with an optional idle gap between repetitions. It drives the detector's `data_in` in loopback benches and the self-test path.

## Interface

Parameters:
- `W`, default 5: maximum pattern width in bits.
- `DEF_PATTERN`, default `5'b10110`: pattern register value after reset.
- `RW`, default 8: width of the repetition count.
- `GW`, default 4: width of the gap count.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request to begin a burst; sampled only in IDLE.
- `pattern_in`, in, W: pattern, MSB transmitted first; latched on an accepted `start`.
- `pat_len`, in, `$clog2(W+1)`: number of valid bits, taken from the MSB end of the pattern; 0 or values above W are treated as W; latched on `start`.
- `reps`, in, RW: number of pattern repetitions; latched on `start`.
- `gap`, in, GW: idle cycles inserted between repetitions; latched on `start`.
- `data_out`, out, 1: serial bit.
- `data_valid`, out, 1: high when `data_out` carries a pattern bit.
- `busy`, out, 1: high from the cycle after an accepted `start` until the cycle DONE is entered.
- `done`, out, 1: one-cycle pulse at the end of a burst.

## Operation

- The state machine is one-hot with four states: IDLE, SEND, GAP, DONE.
- **IDLE**
  - `start` = 1 and `reps` ≠ 0: latch all configuration, load the shift register, set the bit counter to the effective length, set the repetition counter to `reps`, then go to SEND.
  - `start` = 1 and `reps` = 0: go directly to DONE; no bits are sent.
  - `start` = 0: stay in IDLE.
- **SEND**
  - Each cycle: `data_out` = current MSB of the shift register, `data_valid` = 1, shift left, decrement the bit counter.
  - On the last bit of a repetition, decrement the repetition counter.
  - If repetitions remain and `gap` ≠ 0, go to GAP.
  - If repetitions remain and `gap` = 0, reload the shift register and continue in SEND with no bubble.
  - If no repetitions remain, go to DONE.
- **GAP**
  - Each cycle: `data_out` = 0, `data_valid` = 0.
  - After exactly `gap` cycles, reload the shift register and go to SEND.
  - No gap follows the final repetition.
- **DONE**
  - `done` = 1 for one cycle, then go to IDLE.
- Configuration inputs are ignored while `busy`; later changes do not affect the burst in flight.
- `start` while `busy` or in DONE is ignored, not queued.
- Counters are unsigned and never wrap. The maximum burst is `(2^RW − 1) × W` bits plus gaps.

## Timing

- Reset (asynchronous assert): state = IDLE, pattern register = DEF_PATTERN, all counters = 0. `data_out`, `data_valid`, `busy`, `done` = 0 immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally; the block has no reset synchroniser of its own.
- Reset mid-burst: the burst is aborted, no `done` pulse is issued, and the block waits in IDLE.
- Start-to-first-bit latency: `start` sampled at edge N, so the first bit is valid after edge N+1. `busy` rises after edge N.
- Burst length: `reps × len + (reps − 1) × gap` cycles of SEND/GAP, then one DONE cycle. `busy` falls in the same cycle `done` pulses.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `pattern_pkg`:
  - one-hot state constants, shared with the detector's encoding style;
  - `DEF_PATTERN` (`5'b10110`);
  - default widths W, RW, GW.
- One sub-module, `pattern_shifter`:
  - W-bit parallel-load shift register with bit-down-counter;
  - ports: load, shift, MSB out, last-bit flag.
- The top level holds the FSM, the repetition and gap counters, and the output registers.

## Test plan

- **Single burst:** reset, then `start` with `pattern_in`=`10110`, `pat_len`=5, `reps`=1, `gap`=0. Required: `data_out` = 1,0,1,1,0 on the 5 cycles after the start edge, `data_valid` high for exactly those 5 cycles, `done` one cycle later. In loopback, the detector asserts `pattern_det` once.
- **Back-to-back repetitions:** `reps`=3, `gap`=0. Required: 15 contiguous valid bits `101101011010110`, `busy` high for 15 cycles plus DONE, a single `done` pulse.
- **Short pattern with gap:** `pattern_in`=`11000`, `pat_len`=2, `reps`=2, `gap`=3. Required: output 1,1, then three cycles with `data_valid`=0 and `data_out`=0, then 1,1, then `done`.
- **Degenerate configuration:**
  - `reps`=0: no valid bits, `done` pulses one cycle after `start`.
  - `pat_len`=0: behaves as `pat_len`=5.
- **Inputs changed during a burst:** a second `start` and new `pattern_in` applied mid-burst. Required: ignored, the original sequence is unchanged, one `done` only.
- **Reset mid-burst:** assert `rst` low on the third bit. Required: all outputs 0 asynchronously, no `done` pulse. After release, a fresh `start` sends the full pattern from its MSB.
